// File: rtl/sgmii_an_ctrl_if.sv
// Purpose : signal bundle between the SGMII autoneg controller and its PCS neighbours.
// Latency : n/a (wires only).
// Backpressure: none; rx_cfg_valid is a one-cycle strobe and every strobe is consumed.
// Ports   : control levels (an_enable, an_restart, rx_sync_ok), received config word
//           (rx_cfg_valid/rx_cfg_word), TX sequencing levels, partner link status,
//           an_state and the an_timeout pulse. master = PCS side, slave = controller.
interface sgmii_an_ctrl_if;
   logic        an_enable;
   logic        an_restart;
   logic        rx_sync_ok;
   logic        rx_cfg_valid;
   logic [15:0] rx_cfg_word;
   logic        sgmii_autoneg_start;
   logic        sgmii_autoneg_ack;
   logic        sgmii_autoneg_idle;
   logic        sgmii_autoneg_done;
   logic        link_up;
   logic [1:0]  link_speed;
   logic        link_duplex;
   logic [2:0]  an_state;
   logic        an_timeout;

   modport master (
      output an_enable, an_restart, rx_sync_ok, rx_cfg_valid, rx_cfg_word,
      input  sgmii_autoneg_start, sgmii_autoneg_ack, sgmii_autoneg_idle, sgmii_autoneg_done,
      input  link_up, link_speed, link_duplex, an_state, an_timeout
   );

   modport slave (
      input  an_enable, an_restart, rx_sync_ok, rx_cfg_valid, rx_cfg_word,
      output sgmii_autoneg_start, sgmii_autoneg_ack, sgmii_autoneg_idle, sgmii_autoneg_done,
      output link_up, link_speed, link_duplex, an_state, an_timeout
   );
endinterface

// File: rtl/sgmii_an_ctrl.sv
// Purpose : SGMII auto-negotiation sequencer (ability match, ack, link timer, link status).
// Latency : all outputs registered; they change on the same edge the state changes.
// Backpressure: none; every rx_cfg_valid strobe is evaluated in the cycle it arrives.
// Ports   : tbi_tx_clk, rst (async, active-high), an (sgmii_an_ctrl_if.slave).
// Option  : define SGMII_AN_WATCHDOG_EN to add a watchdog that restarts negotiation
//           when ABILITY_DETECT/ACK_DETECT last WATCHDOG_LIMIT cycles; otherwise
//           an_timeout is tied low and those states wait indefinitely.
module sgmii_an_ctrl #(
   parameter logic [15:0] LINK_TIMER     = 16'd40000,
   parameter logic [2:0]  MATCH_COUNT    = 3'd3,
   parameter logic [19:0] WATCHDOG_LIMIT = 20'd1000000
) (
   input logic            tbi_tx_clk,
   input logic            rst,
   sgmii_an_ctrl_if.slave an
);

   typedef enum logic [2:0] {
      ST_DISABLE        = 3'd0,
      ST_RESTART        = 3'd1,
      ST_ABILITY_DETECT = 3'd2,
      ST_ACK_DETECT     = 3'd3,
      ST_COMPLETE_ACK   = 3'd4,
      ST_IDLE_DETECT    = 3'd5,
      ST_LINK_OK        = 3'd6
   } an_state_t;

   an_state_t   state, state_nxt;
   logic [15:0] tmr;
   logic [2:0]  match_cnt, cnt_nxt;
   logic [15:0] cap_word, cap_nxt;
   logic [15:0] ability, abil_nxt;
   logic        tmr_clr;
   logic        wd_fire;

   // Bit 14 is the ack flag; it is excluded from every ability comparison.
   logic [15:0] cfg_masked;
   logic        cfg_zero;
   logic        tmr_done;
   logic        timed_nxt;

   assign cfg_masked = {an.rx_cfg_word[15], 1'b0, an.rx_cfg_word[13:0]};
   assign cfg_zero   = (cfg_masked == 16'd0);
   assign tmr_done   = (tmr == LINK_TIMER - 16'd1);
   assign timed_nxt  = (state_nxt == ST_RESTART) || (state_nxt == ST_COMPLETE_ACK) ||
                       (state_nxt == ST_IDLE_DETECT);

`ifdef SGMII_AN_WATCHDOG_EN
   logic [19:0] wd_cnt;
   logic        wd_active;
   logic        wd_expired;
   logic        timeout_q;

   assign wd_active  = (state == ST_ABILITY_DETECT) || (state == ST_ACK_DETECT);
   assign wd_expired = wd_active && (wd_cnt == WATCHDOG_LIMIT - 20'd1);

   // Keeps counting across ABILITY_DETECT -> ACK_DETECT: both are "waiting on partner".
   always_ff @(posedge tbi_tx_clk or posedge rst) begin
      if (rst) begin
         wd_cnt    <= 20'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_fire;
         if (wd_active && ((state_nxt == ST_ABILITY_DETECT) || (state_nxt == ST_ACK_DETECT)))
            wd_cnt <= wd_cnt + 20'd1;
         else
            wd_cnt <= 20'd0;
      end
   end

   assign an.an_timeout = timeout_q;
`else
   logic [19:0] unused_wd_limit;
   assign unused_wd_limit = WATCHDOG_LIMIT;
   assign an.an_timeout   = 1'b0;
`endif

   always_ff @(posedge tbi_tx_clk or posedge rst) begin
      if (rst) state <= ST_DISABLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tmr_clr   = 1'b0;
      wd_fire   = 1'b0;
      cnt_nxt   = match_cnt;
      cap_nxt   = cap_word;
      abil_nxt  = ability;
      if (!an.an_enable || !an.rx_sync_ok) begin
         state_nxt = ST_DISABLE;
      end else if (an.an_restart) begin
         // Re-entering RESTART from RESTART must still restart the link timer.
         state_nxt = ST_RESTART;
         tmr_clr   = 1'b1;
`ifdef SGMII_AN_WATCHDOG_EN
      end else if (wd_expired) begin
         state_nxt = ST_RESTART;
         wd_fire   = 1'b1;
`endif
      end else begin
         case (state)
            ST_DISABLE: state_nxt = ST_RESTART;
            ST_RESTART: if (tmr_done) state_nxt = ST_ABILITY_DETECT;
            ST_ABILITY_DETECT: begin
               if (an.rx_cfg_valid) begin
                  if (cfg_zero) begin
                     cnt_nxt = 3'd0;
                  end else if (cfg_masked == cap_word) begin
                     cnt_nxt = match_cnt + 3'd1;
                  end else begin
                     cnt_nxt = 3'd1;
                     cap_nxt = cfg_masked;
                  end
                  if (!cfg_zero && (cnt_nxt == MATCH_COUNT)) begin
                     state_nxt = ST_ACK_DETECT;
                     abil_nxt  = cfg_masked;
                  end
               end
            end
            ST_ACK_DETECT: begin
               if (an.rx_cfg_valid) begin
                  if (cfg_zero || (cfg_masked != ability)) state_nxt = ST_RESTART;
                  else if (an.rx_cfg_word[14])             state_nxt = ST_COMPLETE_ACK;
               end
            end
            // Config-word checks come before timer expiry so a zero word on the
            // last timer cycle still aborts.
            ST_COMPLETE_ACK: begin
               if (an.rx_cfg_valid && cfg_zero) state_nxt = ST_RESTART;
               else if (tmr_done)               state_nxt = ST_IDLE_DETECT;
            end
            ST_IDLE_DETECT: begin
               if (an.rx_cfg_valid && cfg_zero) state_nxt = ST_RESTART;
               else if (tmr_done)               state_nxt = ST_LINK_OK;
            end
            ST_LINK_OK: if (an.rx_cfg_valid) state_nxt = ST_RESTART;
            default: state_nxt = ST_DISABLE;
         endcase
      end
   end

   // Timer restarts on every state entry; saturation guards against a wrap if
   // LINK_TIMER is ever set to 0.
   always_ff @(posedge tbi_tx_clk or posedge rst) begin
      if (rst) begin
         tmr <= 16'd0;
      end else if (tmr_clr || (state_nxt != state) || !timed_nxt) begin
         tmr <= 16'd0;
      end else if (tmr != 16'hFFFF) begin
         tmr <= tmr + 16'd1;
      end
   end

   // The run length only means something inside ABILITY_DETECT; it starts from
   // zero on each visit.
   always_ff @(posedge tbi_tx_clk or posedge rst) begin
      if (rst) begin
         match_cnt <= 3'd0;
         cap_word  <= 16'd0;
         ability   <= 16'd0;
      end else begin
         match_cnt <= (state_nxt == ST_ABILITY_DETECT) ? cnt_nxt : 3'd0;
         cap_word  <= cap_nxt;
         ability   <= abil_nxt;
      end
   end

   logic       start_q, ack_q, idle_q, done_q, link_up_q, duplex_q;
   logic [1:0] speed_q;
   logic       link_ok_nxt;

   assign link_ok_nxt = (state_nxt == ST_LINK_OK);

   always_ff @(posedge tbi_tx_clk or posedge rst) begin
      if (rst) begin
         start_q   <= 1'b0;
         ack_q     <= 1'b0;
         idle_q    <= 1'b0;
         done_q    <= 1'b0;
         link_up_q <= 1'b0;
         speed_q   <= 2'b00;
         duplex_q  <= 1'b0;
      end else begin
         start_q   <= (state_nxt == ST_ABILITY_DETECT) || (state_nxt == ST_ACK_DETECT) ||
                      (state_nxt == ST_COMPLETE_ACK) || (state_nxt == ST_IDLE_DETECT) ||
                      link_ok_nxt;
         ack_q     <= (state_nxt == ST_ACK_DETECT) || (state_nxt == ST_COMPLETE_ACK) ||
                      (state_nxt == ST_IDLE_DETECT) || link_ok_nxt;
         idle_q    <= (state_nxt == ST_IDLE_DETECT) || link_ok_nxt;
         done_q    <= link_ok_nxt;
         link_up_q <= link_ok_nxt & abil_nxt[15];
         speed_q   <= link_ok_nxt ? abil_nxt[11:10] : 2'b00;
         duplex_q  <= link_ok_nxt & abil_nxt[12];
      end
   end

   assign an.sgmii_autoneg_start = start_q;
   assign an.sgmii_autoneg_ack   = ack_q;
   assign an.sgmii_autoneg_idle  = idle_q;
   assign an.sgmii_autoneg_done  = done_q;
   assign an.link_up             = link_up_q;
   assign an.link_speed          = speed_q;
   assign an.link_duplex         = duplex_q;
   assign an.an_state            = state;

endmodule

// File: tb/tb_sgmii_an_ctrl.sv
// Purpose : self-checking bench for sgmii_an_ctrl (LINK_TIMER=16, WATCHDOG_LIMIT=64).
// Latency : outputs checked on the falling edge after each rising edge.
// Backpressure: none; stimulus is one vector per cycle.
module tb_sgmii_an_ctrl;
   localparam int LT = 16;
   localparam int MC = 3;
   localparam int WD = 64;
`ifdef SGMII_AN_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic tbi_tx_clk = 1'b0;
   logic rst;
   always #5 tbi_tx_clk = ~tbi_tx_clk;

   sgmii_an_ctrl_if bus();

   sgmii_an_ctrl #(
      .LINK_TIMER(16'd16),
      .MATCH_COUNT(3'd3),
      .WATCHDOG_LIMIT(20'd64)
   ) dut (
      .tbi_tx_clk(tbi_tx_clk),
      .rst(rst),
      .an(bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: negotiation phase, cycles spent in the phase, run of
   // identical ability words seen, partner ability, watchdog age.
   int          m_state, m_el, m_wd;
   bit          m_to;
   logic [15:0] m_ab;
   logic [15:0] m_run[$];

   task automatic mdl_reset();
      m_state = 0; m_el = 0; m_wd = 0; m_to = 1'b0; m_ab = 16'h0;
      m_run.delete();
   endtask

   task automatic mdl_step(input int en, input int sync, input int rs, input int v,
                           input logic [15:0] w);
      int          nxt;
      bit          to;
      bit          waiting;
      logic [15:0] wm;
      wm = w & 16'hBFFF;
      nxt = m_state;
      to = 1'b0;
      waiting = (m_state == 2) || (m_state == 3);
      if (en == 0 || sync == 0) nxt = 0;
      else if (rs != 0) nxt = 1;
      else if (WD_ON && waiting && m_wd == WD - 1) begin nxt = 1; to = 1'b1; end
      else begin
         case (m_state)
            0: nxt = 1;
            1: if (m_el == LT - 1) nxt = 2;
            2: if (v != 0) begin
                  if (wm == 16'h0) m_run.delete();
                  else begin
                     if (m_run.size() == 0 || m_run[0] != wm) m_run.delete();
                     m_run.push_back(wm);
                     if (m_run.size() == MC) begin nxt = 3; m_ab = wm; end
                  end
               end
            3: if (v != 0) begin
                  if (wm == 16'h0 || wm != m_ab) nxt = 1;
                  else if (w[14]) nxt = 4;
               end
            4: if (v != 0 && wm == 16'h0) nxt = 1; else if (m_el == LT - 1) nxt = 5;
            5: if (v != 0 && wm == 16'h0) nxt = 1; else if (m_el == LT - 1) nxt = 6;
            6: if (v != 0) nxt = 1;
            default: nxt = 0;
         endcase
      end
      if (nxt != m_state || (en != 0 && sync != 0 && rs != 0)) m_el = 0;
      else m_el = m_el + 1;
      m_wd = (waiting && (nxt == 2 || nxt == 3)) ? m_wd + 1 : 0;
      if (nxt == 2 && m_state != 2) m_run.delete();
      m_state = nxt;
      m_to = to;
   endtask

   function automatic logic [11:0] mdl_vec();
      logic       lo;
      logic [3:0] lnk;
      lo  = (m_state == 6);
      lnk = lo ? {m_ab[15], m_ab[11:10], m_ab[12]} : 4'h0;
      return {3'(m_state), m_state >= 2, m_state >= 3, m_state >= 5, lo, lnk, m_to};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {bus.an_state, bus.sgmii_autoneg_start, bus.sgmii_autoneg_ack,
              bus.sgmii_autoneg_idle, bus.sgmii_autoneg_done, bus.link_up,
              bus.link_speed, bus.link_duplex, bus.an_timeout};
   endfunction

   // One clock of stimulus; the model is stepped on the same rising edge.
   task automatic tick(input int en, input int sync, input int rs, input int v,
                       input logic [15:0] w);
      bus.an_enable    = (en != 0);
      bus.rx_sync_ok   = (sync != 0);
      bus.an_restart   = (rs != 0);
      bus.rx_cfg_valid = (v != 0);
      bus.rx_cfg_word  = w;
      @(posedge tbi_tx_clk);
      if (rst) mdl_reset();
      else mdl_step(en, sync, rs, v, w);
      @(negedge tbi_tx_clk);
   endtask

   task automatic goto_ack();
      tick(1, 1, 1, 0, 16'h0);
      for (int i = 0; i < LT; i++) tick(1, 1, 0, 0, 16'h0);
      for (int i = 0; i < MC; i++) tick(1, 1, 0, 1, 16'h9801);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mdl_reset();
      for (int i = 0; i < 4; i++) begin
         tick(1, 1, i & 1, 1, 16'h9801);
         n_vec++;
         if (dut_vec() !== 12'h000) begin
            n_bad++; $display("FAIL reset_hold[%0d]: dut=%h want=000", i, dut_vec());
         end
      end
      rst = 1'b0;
      tick(0, 1, 0, 0, 16'h0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
         n_bad++; $display("FAIL reset_release: dut=%h model=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_bringup();
      int n;
      tick(1, 1, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_state !== 3'd1) begin
         n_bad++; $display("FAIL bringup_restart: state=%0d want=1", bus.an_state);
      end
      n = 0;
      for (int i = 0; i < 40 && bus.an_state != 3'd2; i++) begin
         tick(1, 1, 0, 0, 16'h0);
         n++;
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL bringup_cycle[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
      n_vec++;
      if (n !== 16 || bus.sgmii_autoneg_start !== 1'b1) begin
         n_bad++; $display("FAIL bringup_timer: cycles=%0d start=%b want 16/1", n, bus.sgmii_autoneg_start);
      end
   endtask

   task automatic test_link();
      int n;
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 0, 1, 16'h9801);
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL link_ability[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
      n_vec++;
      if (bus.an_state !== 3'd3) begin
         n_bad++; $display("FAIL link_ackdet: state=%0d want=3", bus.an_state);
      end
      tick(1, 1, 0, 1, 16'hD801);
      n = 0;
      for (int i = 0; i < 60 && bus.an_state != 3'd6; i++) begin
         tick(1, 1, 0, (i < 2) ? 1 : 0, 16'hD801);
         n++;
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL link_cycle[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
      n_vec++;
      if (n !== 32) begin
         n_bad++; $display("FAIL link_timing: cycles=%0d want=32", n);
      end
      n_vec++;
      if ({bus.link_up, bus.link_speed, bus.link_duplex} !== 4'b1101) begin
         n_bad++; $display("FAIL link_status: up=%b speed=%b duplex=%b want 1/10/1",
                           bus.link_up, bus.link_speed, bus.link_duplex);
      end
   endtask

   task automatic test_sync_drop();
      tick(1, 0, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_state !== 3'd0 || bus.link_up !== 1'b0 || dut_vec() !== mdl_vec()) begin
         n_bad++; $display("FAIL sync_drop: dut=%h want state 0 link_up 0", dut_vec());
      end
      tick(1, 1, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_state !== 3'd1) begin
         n_bad++; $display("FAIL sync_back: state=%0d want=1", bus.an_state);
      end
   endtask

   task automatic test_ack_mismatch();
      goto_ack();
      n_vec++;
      if (bus.an_state !== 3'd3 || dut_vec() !== mdl_vec()) begin
         n_bad++; $display("FAIL ackmis_setup: dut=%h model=%h", dut_vec(), mdl_vec());
      end
      tick(1, 1, 0, 1, 16'hD401);
      n_vec++;
      if (bus.an_state !== 3'd1 || dut_vec()[8:5] !== 4'b0000) begin
         n_bad++; $display("FAIL ackmis_restart: dut=%h want state 1, seq outputs 0", dut_vec());
      end
   endtask

   task automatic test_match_reload();
      logic [15:0] seq[4];
      seq = '{16'h9801, 16'h9401, 16'h9401, 16'h9401};
      tick(1, 1, 1, 0, 16'h0);
      for (int i = 0; i < LT; i++) tick(1, 1, 0, 0, 16'h0);
      for (int i = 0; i < 4; i++) begin
         tick(1, 1, 0, 1, seq[i]);
         n_vec++;
         if (bus.an_state !== ((i == 3) ? 3'd3 : 3'd2) || dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL reload[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_coincident();
      goto_ack();
      tick(1, 1, 0, 1, 16'hD801);
      for (int i = 0; i < LT - 1; i++) tick(1, 1, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_state !== 3'd4) begin
         n_bad++; $display("FAIL coinc_setup: state=%0d want=4", bus.an_state);
      end
      tick(1, 1, 0, 1, 16'h4000);
      n_vec++;
      if (bus.an_state !== 3'd1 || dut_vec() !== mdl_vec()) begin
         n_bad++; $display("FAIL coinc_zero_wins: dut=%h model=%h want state 1", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_watchdog();
      int n;
      bit seen;
      tick(1, 1, 1, 0, 16'h0);
      for (int i = 0; i < LT; i++) tick(1, 1, 0, 0, 16'h0);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick(1, 1, 0, 0, 16'h0);
         n++;
         seen = (bus.an_timeout === 1'b1);
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL wd_cycle[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
`ifdef SGMII_AN_WATCHDOG_EN
      n_vec++;
      if (!seen || n !== 64 || bus.an_state !== 3'd1) begin
         n_bad++; $display("FAIL wd_fire: seen=%b cycles=%0d state=%0d want 1/64/1", seen, n, bus.an_state);
      end
      tick(1, 1, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_timeout !== 1'b0) begin
         n_bad++; $display("FAIL wd_pulse_width: an_timeout=%b want=0", bus.an_timeout);
      end
`else
      n_vec++;
      if (seen || bus.an_state !== 3'd2) begin
         n_bad++; $display("FAIL wd_absent: seen=%b state=%0d want 0/2", seen, bus.an_state);
      end
`endif
   endtask

   task automatic test_rst_midseq();
      goto_ack();
      rst = 1'b1;
      #1;
      mdl_reset();
      n_vec++;
      if (dut_vec() !== 12'h000) begin
         n_bad++; $display("FAIL rst_async: dut=%h want=000", dut_vec());
      end
      @(negedge tbi_tx_clk);
      tick(1, 1, 0, 1, 16'hD801);
      n_vec++;
      if (dut_vec() !== 12'h000) begin
         n_bad++; $display("FAIL rst_hold: dut=%h want=000", dut_vec());
      end
      rst = 1'b0;
      tick(1, 1, 0, 0, 16'h0);
      n_vec++;
      if (bus.an_state !== 3'd1 || dut_vec() !== mdl_vec()) begin
         n_bad++; $display("FAIL rst_resume: dut=%h model=%h", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_random();
      logic [15:0] bases[4];
      logic [15:0] base, w;
      int          r, en, sync, rs, v, bad_here;
      bases = '{16'h9801, 16'h9401, 16'h8C01, 16'h1801};
      base = bases[0];
      bad_here = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) base = bases[$urandom_range(0, 3)];
         en   = ($urandom_range(0, 299) != 0) ? 1 : 0;
         sync = ($urandom_range(0, 199) != 0) ? 1 : 0;
         rs   = ($urandom_range(0, 399) == 0) ? 1 : 0;
         v    = ($urandom_range(0, 3) == 0) ? 1 : 0;
         r    = int'($urandom_range(0, 99));
         if (r < 45)      w = base;
         else if (r < 85) w = base | 16'h4000;
         else if (r < 88) w = 16'h0000;
         else if (r < 91) w = 16'h4000;
         else if (r < 95) w = base ^ 16'h0400;
         else             w = 16'($urandom);
         tick(en, sync, rs, v, w);
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            bad_here++;
            if (bad_here <= 10)
               $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      bus.an_enable    = 1'b0;
      bus.an_restart   = 1'b0;
      bus.rx_sync_ok   = 1'b0;
      bus.rx_cfg_valid = 1'b0;
      bus.rx_cfg_word  = 16'h0;
      rst = 1'b1;
      @(negedge tbi_tx_clk);
      test_reset();
      test_bringup();
      test_link();
      test_sync_drop();
      test_ack_mismatch();
      test_match_reload();
      test_coincident();
      test_watchdog();
      test_rst_midseq();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
